// File: rtl/esm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : esm_pkg
// Brief   : Shared slot-state encodings and index-width helper for the ESM
//           issue buffer.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package esm_pkg;

  // Life cycle of one buffer slot.
  typedef enum logic [1:0] {
    SLOT_FREE   = 2'd0,
    SLOT_WAIT   = 2'd1,
    SLOT_READY  = 2'd2,
    SLOT_ISSUED = 2'd3
  } slot_state_t;

  // Width of a slot index for a buffer of n slots (at least one bit).
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/esm_index_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : esm_index_fifo
// Brief   : Circular FIFO of slot indices with wrapping pointers. Pops while
//           empty are ignored; pushes never overflow because each slot index
//           can be resident at most once.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module esm_index_fifo
  import esm_pkg::*;
#(
  parameter  int bs      = 16,
  localparam int bs_bits = idx_bits(bs)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [bs_bits-1:0] push_index,
  input  logic               pop,
  output logic               empty,
  output logic [bs_bits-1:0] head
);

  logic [bs_bits-1:0] mem [bs];
  logic [bs_bits-1:0] wr_ptr;
  logic [bs_bits-1:0] rd_ptr;
  logic [bs_bits:0]   count;
  logic               pop_ok;

  assign empty  = (count == '0);
  assign head   = mem[rd_ptr];
  assign pop_ok = pop && !empty;

  // Entry storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_index;
    end
  end

  // Pointers wrap naturally because bs is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/esm_issue_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : esm_issue_buffer
// Brief   : Instruction buffer and issue stage. Allocates the lowest free
//           slot to each fetched instruction, queues slots reported ready by
//           the dependency core, issues them oldest-ready-first and frees
//           them on completion. Illegal ready/done events set a sticky err.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module esm_issue_buffer
  import esm_pkg::*;
#(
  parameter  int Instr_word_size = 32,
  parameter  int bs              = 16,
  localparam int bs_bits         = idx_bits(bs)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [Instr_word_size-1:0] in_instr,
  output logic [bs_bits-1:0]         alloc_index,
  input  logic                       rdy_valid,
  input  logic [bs_bits-1:0]         rdy_index,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [Instr_word_size-1:0] issue_instr,
  output logic [bs_bits-1:0]         issue_index,
  input  logic                       done_valid,
  input  logic [bs_bits-1:0]         done_index,
  output logic [bs_bits:0]           free_count,
  output logic                       err
);

  slot_state_t                slot_q  [bs];
  logic [Instr_word_size-1:0] storage [bs];

  logic [bs_bits-1:0] first_free;
  logic [bs_bits:0]   free_cnt;
  logic               alloc_fire;
  logic               rdy_ok;
  logic               done_ok;
  logic               issue_fire;
  logic               fifo_empty;
  logic [bs_bits-1:0] fifo_head;

  // Lowest-numbered free slot and popcount of free slots, from registered state.
  always_comb begin
    first_free = '0;
    free_cnt   = '0;
    for (int i = bs - 1; i >= 0; i--) begin
      if (slot_q[i] == SLOT_FREE) begin
        first_free = bs_bits'(i);
        free_cnt   = free_cnt + (bs_bits + 1)'(1);
      end
    end
  end

  assign in_ready    = (free_cnt != '0);
  assign alloc_index = first_free;
  assign free_count  = free_cnt;

  assign alloc_fire  = in_valid && in_ready;
  assign rdy_ok      = rdy_valid  && (slot_q[rdy_index]  == SLOT_WAIT);
  assign done_ok     = done_valid && (slot_q[done_index] == SLOT_ISSUED);

  assign issue_valid = !fifo_empty;
  assign issue_index = fifo_head;
  assign issue_instr = storage[fifo_head];
  assign issue_fire  = issue_valid && issue_ready;

  esm_index_fifo #(
    .bs (bs)
  ) u_ready_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (rdy_ok),
    .push_index (rdy_index),
    .pop        (issue_fire),
    .empty      (fifo_empty),
    .head       (fifo_head)
  );

  // Capture the instruction word into its newly allocated slot.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      storage[alloc_index] <= in_instr;
    end
  end

  // Slot state transitions; legal concurrent events always target distinct slots.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < bs; i++) begin
        slot_q[i] <= SLOT_FREE;
      end
    end else begin
      if (alloc_fire) slot_q[alloc_index] <= SLOT_WAIT;
      if (rdy_ok)     slot_q[rdy_index]   <= SLOT_READY;
      if (issue_fire) slot_q[issue_index] <= SLOT_ISSUED;
      if (done_ok)    slot_q[done_index]  <= SLOT_FREE;
    end
  end

  // Sticky protocol-violation flag for ready/done on a slot in the wrong state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if ((rdy_valid && !rdy_ok) || (done_valid && !done_ok)) begin
      err <= 1'b1;
    end
  end

endmodule
`default_nettype wire
